// File: rtl/axi_pkg.sv
// axi_pkg: AXI3 payload types, widths, master indices and FSM encodings for the 2:1 arbiter
package axi_pkg;
  localparam int ID_W = 4;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;
  localparam int LEN_W = 4;
  localparam logic M_DCACHE = 1'b0;
  localparam logic M_ICACHE = 1'b1;
  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_ADDR = 2'd1;
  localparam logic [1:0] R_DATA = 2'd2;
  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_ADDR = 2'd1;
  localparam logic [1:0] W_DATA = 2'd2;
  localparam logic [1:0] W_RESP = 2'd3;
  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
    logic [2:0]        size;
    logic [1:0]        burst;
    logic [1:0]        lock;
    logic [3:0]        cache;
    logic [2:0]        prot;
    logic [3:0]        qos;
  } axi_addr_t;
  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] data;
    logic [STRB_W-1:0] strb;
    logic              last;
  } axi_w_t;
  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] data;
    logic [1:0]        resp;
    logic              last;
  } axi_r_t;
  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [1:0]      resp;
  } axi_b_t;
  // steer a single handshake bit to the owning master's lane
  function automatic logic [1:0] sel_vec(input logic sel, input logic en);
    return {en & sel, en & ~sel};
  endfunction
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-request grant with a preference pointer that moves to the loser on completion
module rr_arb2 import axi_pkg::*; #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_req,
  input  logic       i_done,
  input  logic       i_winner,
  output logic       o_gnt
);
  logic r_ptr;
  always_comb o_gnt = FIXED_PRIO ? (i_req[M_DCACHE] ? M_DCACHE : M_ICACHE)
                                 : (&i_req ? r_ptr : i_req[M_ICACHE]);
  always_ff @(posedge clk) begin
    if (rst) r_ptr <= M_DCACHE;
    else if (i_done) r_ptr <= ~i_winner;
  end
endmodule

// File: rtl/axi_arbiter_2to1.sv
// axi_arbiter_2to1: dcache/icache share one AXI3 port; read and write paths are arbitrated
// independently, each locked to one owner from address grant to final response.
module axi_arbiter_2to1 import axi_pkg::*; #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  axi_addr_t [1:0] s_ar,
  input  logic      [1:0] s_arvalid,
  output logic      [1:0] s_arready,
  output axi_r_t          s_r,
  output logic      [1:0] s_rvalid,
  input  logic      [1:0] s_rready,
  input  axi_addr_t [1:0] s_aw,
  input  logic      [1:0] s_awvalid,
  output logic      [1:0] s_awready,
  input  axi_w_t    [1:0] s_w,
  input  logic      [1:0] s_wvalid,
  output logic      [1:0] s_wready,
  output axi_b_t          s_b,
  output logic      [1:0] s_bvalid,
  input  logic      [1:0] s_bready,
  output axi_addr_t       m_ar,
  output logic            m_arvalid,
  input  logic            m_arready,
  input  axi_r_t          m_r,
  input  logic            m_rvalid,
  output logic            m_rready,
  output axi_addr_t       m_aw,
  output logic            m_awvalid,
  input  logic            m_awready,
  output axi_w_t          m_w,
  output logic            m_wvalid,
  input  logic            m_wready,
  input  axi_b_t          m_b,
  input  logic            m_bvalid,
  output logic            m_bready
);
  logic [1:0] r_rd_state, r_wr_state;
  logic       r_rd_owner, r_wr_owner;
  logic       w_rd_gnt, w_wr_gnt, w_rd_done, w_wr_done, w_wlast;
  rr_arb2 #(.FIXED_PRIO(FIXED_PRIO)) u_rd_arb (
    .clk(clk), .rst(rst), .i_req(s_arvalid), .i_done(w_rd_done), .i_winner(r_rd_owner), .o_gnt(w_rd_gnt)
  );
  rr_arb2 #(.FIXED_PRIO(FIXED_PRIO)) u_wr_arb (
    .clk(clk), .rst(rst), .i_req(s_awvalid), .i_done(w_wr_done), .i_winner(r_wr_owner), .o_gnt(w_wr_gnt)
  );
  // the registered owner steers every channel; the returned IDs are never consulted
  always_comb begin
    m_ar      = s_ar[r_rd_owner];
    m_arvalid = (r_rd_state == R_ADDR) & s_arvalid[r_rd_owner];
    s_arready = sel_vec(r_rd_owner, (r_rd_state == R_ADDR) & m_arready);
    s_r       = m_r;
    s_rvalid  = sel_vec(r_rd_owner, (r_rd_state == R_DATA) & m_rvalid);
    m_rready  = (r_rd_state == R_DATA) & s_rready[r_rd_owner];
    w_rd_done = m_rvalid & m_rready & m_r.last;
    m_aw      = s_aw[r_wr_owner];
    m_awvalid = (r_wr_state == W_ADDR) & s_awvalid[r_wr_owner];
    s_awready = sel_vec(r_wr_owner, (r_wr_state == W_ADDR) & m_awready);
    m_w       = s_w[r_wr_owner];
    m_wvalid  = (r_wr_state == W_DATA) & s_wvalid[r_wr_owner];
    s_wready  = sel_vec(r_wr_owner, (r_wr_state == W_DATA) & m_wready);
    w_wlast   = m_wvalid & m_wready & m_w.last;
    s_b       = m_b;
    s_bvalid  = sel_vec(r_wr_owner, (r_wr_state == W_RESP) & m_bvalid);
    m_bready  = (r_wr_state == W_RESP) & s_bready[r_wr_owner];
    w_wr_done = m_bvalid & m_bready;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_state <= R_IDLE;
      r_rd_owner <= M_DCACHE;
    end else begin
      r_rd_state <= (r_rd_state == R_IDLE) ? (|s_arvalid ? R_ADDR : R_IDLE)
                  : (r_rd_state == R_ADDR) ? (m_arvalid & m_arready ? R_DATA : R_ADDR)
                  : (r_rd_state == R_DATA && !w_rd_done) ? R_DATA : R_IDLE;
      if (r_rd_state == R_IDLE && |s_arvalid) r_rd_owner <= w_rd_gnt;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_state <= W_IDLE;
      r_wr_owner <= M_DCACHE;
    end else begin
      r_wr_state <= (r_wr_state == W_IDLE) ? (|s_awvalid ? W_ADDR : W_IDLE)
                  : (r_wr_state == W_ADDR) ? (m_awvalid & m_awready ? W_DATA : W_ADDR)
                  : (r_wr_state == W_DATA) ? (w_wlast ? W_RESP : W_DATA)
                  : (w_wr_done ? W_IDLE : W_RESP);
      if (r_wr_state == W_IDLE && |s_awvalid) r_wr_owner <= w_wr_gnt;
    end
  end
endmodule

// File: tb/tb_axi_arbiter_2to1.sv
// tb_axi_arbiter_2to1: directed scenarios for the 2:1 AXI arbiter, round-robin and fixed-priority builds
module tb_axi_arbiter_2to1;
  import axi_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  axi_addr_t [1:0] s_ar, s_aw;
  axi_w_t    [1:0] s_w;
  logic [1:0] s_arvalid, s_arready, s_rvalid, s_rready, s_awvalid, s_awready;
  logic [1:0] s_wvalid, s_wready, s_bvalid, s_bready;
  axi_r_t s_r, m_r;
  axi_b_t s_b, m_b;
  axi_addr_t m_ar, m_aw;
  axi_w_t m_w;
  logic m_arvalid, m_arready, m_rvalid, m_rready, m_awvalid, m_awready;
  logic m_wvalid, m_wready, m_bvalid, m_bready;
  logic [1:0] f_arvalid, f_arready, f_rvalid, f_rready, f_awready, f_wready, f_bvalid;
  axi_r_t f_r;
  axi_b_t f_b;
  axi_addr_t f_m_ar, f_m_aw;
  axi_w_t f_m_w;
  logic f_m_arvalid, f_m_arready, f_m_rvalid, f_m_rready, f_m_awvalid, f_m_wvalid, f_m_bready;
  int nv = 0;
  int nm = 0;

  axi_arbiter_2to1 #(.FIXED_PRIO(1'b0)) dut (
    .clk(clk), .rst(rst),
    .s_ar(s_ar), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_r(s_r), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .s_aw(s_aw), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_w(s_w), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_b(s_b), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .m_ar(m_ar), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_r(m_r), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_aw(m_aw), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_w(m_w), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_b(m_b), .m_bvalid(m_bvalid), .m_bready(m_bready)
  );

  axi_arbiter_2to1 #(.FIXED_PRIO(1'b1)) u_fp (
    .clk(clk), .rst(rst),
    .s_ar(s_ar), .s_arvalid(f_arvalid), .s_arready(f_arready),
    .s_r(f_r), .s_rvalid(f_rvalid), .s_rready(f_rready),
    .s_aw(s_aw), .s_awvalid(2'b00), .s_awready(f_awready),
    .s_w(s_w), .s_wvalid(2'b00), .s_wready(f_wready),
    .s_b(f_b), .s_bvalid(f_bvalid), .s_bready(2'b00),
    .m_ar(f_m_ar), .m_arvalid(f_m_arvalid), .m_arready(f_m_arready),
    .m_r(m_r), .m_rvalid(f_m_rvalid), .m_rready(f_m_rready),
    .m_aw(f_m_aw), .m_awvalid(f_m_awvalid), .m_awready(1'b0),
    .m_w(f_m_w), .m_wvalid(f_m_wvalid), .m_wready(1'b0),
    .m_b(m_b), .m_bvalid(1'b0), .m_bready(f_m_bready)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic rd_burst(input logic [1:0] own, input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      m_rvalid = 1'b1;
      m_r.data = base + i;
      m_r.last = (i == n - 1);
      #1;
      nv++;
      if (s_rvalid !== own || m_rready !== 1'b1 || s_r.data !== base + i || s_r.last !== (i == n - 1)) begin
        nm++;
        $display("FAIL rd_beat%0d: rvalid=%b rready=%b data=%h last=%b, want %b 1 %h %b",
                 i, s_rvalid, m_rready, s_r.data, s_r.last, own, base + i, (i == n - 1));
      end
      tick;
    end
    m_rvalid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    s_arvalid = 2'b11; s_awvalid = 2'b11; s_wvalid = 2'b11;
    s_rready = 2'b11; s_bready = 2'b11;
    s_ar[0].addr = 32'h1FC0_0000; s_ar[1].addr = 32'hBFC0_0000;
    m_arready = 1'b1; m_rvalid = 1'b1; m_awready = 1'b1; m_wready = 1'b1; m_bvalid = 1'b1;
    repeat (3) tick;
    #1;
    nv++;
    if ({s_arready, s_rvalid, s_awready, s_wready, s_bvalid, m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready} !== 15'd0) begin
      nm++;
      $display("FAIL reset_handshakes: got %b want all zero",
               {s_arready, s_rvalid, s_awready, s_wready, s_bvalid, m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready});
    end
    rst = 1'b0;
    #1;
    nv++;
    if (m_arvalid !== 1'b0 || m_awvalid !== 1'b0) begin
      nm++;
      $display("FAIL post_reset_valid: arvalid=%b awvalid=%b want 0 0", m_arvalid, m_awvalid);
    end
    nv++;
    if (m_ar.addr !== 32'h1FC0_0000) begin
      nm++;
      $display("FAIL post_reset_addr: got %h want 1fc00000", m_ar.addr);
    end
    s_arvalid = 2'b00; s_awvalid = 2'b00; s_wvalid = 2'b00;
    m_rvalid = 1'b0; m_bvalid = 1'b0;
    tick;
  endtask

  task automatic test_round_robin;
    s_ar[0] = '0; s_ar[0].id = 4'h1; s_ar[0].addr = 32'h8000_0040; s_ar[0].len = 4'd3;
    s_ar[1] = '0; s_ar[1].id = 4'h2; s_ar[1].addr = 32'hBFC0_0000; s_ar[1].len = 4'd3;
    s_arvalid = 2'b11; m_arready = 1'b1; s_rready = 2'b11;
    #1;
    nv++;
    if (m_arvalid !== 1'b0) begin nm++; $display("FAIL rr_bubble: m_arvalid=%b want 0", m_arvalid); end
    tick;
    nv++;
    if (m_arvalid !== 1'b1 || s_arready !== 2'b01 || m_ar.addr !== 32'h8000_0040 || m_ar.id !== 4'h1) begin
      nm++;
      $display("FAIL rr_first_dcache: valid=%b arready=%b addr=%h id=%h want 1 01 80000040 1", m_arvalid, s_arready, m_ar.addr, m_ar.id);
    end
    tick;
    s_arvalid = 2'b10;
    rd_burst(2'b01, 4, 32'hD000_0000);
    s_ar[0].addr = 32'h8000_0080; s_ar[0].len = 4'd0;
    s_arvalid = 2'b11;
    #1;
    nv++;
    if (m_arvalid !== 1'b0 || s_arready !== 2'b00) begin
      nm++;
      $display("FAIL rr_turnaround: valid=%b arready=%b want 0 00", m_arvalid, s_arready);
    end
    tick;
    nv++;
    if (s_arready !== 2'b10 || m_ar.addr !== 32'hBFC0_0000 || m_ar.id !== 4'h2) begin
      nm++;
      $display("FAIL rr_second_icache: arready=%b addr=%h id=%h want 10 bfc00000 2", s_arready, m_ar.addr, m_ar.id);
    end
    tick;
    s_arvalid = 2'b01;
    rd_burst(2'b10, 4, 32'h1C00_0000);
    tick;
    nv++;
    if (s_arready !== 2'b01 || m_ar.addr !== 32'h8000_0080) begin
      nm++;
      $display("FAIL rr_third_dcache: arready=%b addr=%h want 01 80000080", s_arready, m_ar.addr);
    end
    tick;
    s_arvalid = 2'b00;
    rd_burst(2'b01, 1, 32'hD000_0100);
  endtask

  task automatic test_concurrent;
    s_ar[1] = '0; s_ar[1].addr = 32'hBFC0_0100; s_ar[1].len = 4'd3;
    s_aw[0] = '0; s_aw[0].id = 4'h3; s_aw[0].addr = 32'h8000_0080; s_aw[0].len = 4'd3;
    s_arvalid = 2'b10; s_awvalid = 2'b01; m_arready = 1'b1; m_awready = 1'b1;
    #1;
    nv++;
    if ({m_arvalid, m_awvalid} !== 2'b00) begin nm++; $display("FAIL cc_bubble: got %b want 00", {m_arvalid, m_awvalid}); end
    tick;
    nv++;
    if (s_arready !== 2'b10 || s_awready !== 2'b01 || m_aw.addr !== 32'h8000_0080 || m_ar.addr !== 32'hBFC0_0100) begin
      nm++;
      $display("FAIL cc_addr: arready=%b awready=%b awaddr=%h araddr=%h want 10 01 80000080 bfc00100", s_arready, s_awready, m_aw.addr, m_ar.addr);
    end
    tick;
    s_arvalid = 2'b00; s_awvalid = 2'b00;
    for (int i = 0; i < 4; i++) begin
      m_rvalid = 1'b1; m_r.data = 32'h100 + i; m_r.last = (i == 3); s_rready = 2'b11;
      s_w[0] = '0; s_w[0].data = 32'hA0 + i; s_w[0].strb = 4'hF; s_w[0].last = (i == 3);
      s_wvalid = 2'b01; m_wready = 1'b1;
      #1;
      nv++;
      if (s_rvalid !== 2'b10 || s_r.data !== 32'h100 + i || s_wready !== 2'b01 || m_wvalid !== 1'b1
          || m_w.data !== 32'hA0 + i || m_w.strb !== 4'hF || m_w.last !== (i == 3)) begin
        nm++;
        $display("FAIL cc_beat%0d: rvalid=%b rdata=%h wready=%b wvalid=%b wdata=%h strb=%h wlast=%b",
                 i, s_rvalid, s_r.data, s_wready, m_wvalid, m_w.data, m_w.strb, m_w.last);
      end
      tick;
    end
    m_rvalid = 1'b0; s_wvalid = 2'b00;
    m_bvalid = 1'b1; m_b.id = 4'h3; m_b.resp = 2'b00; s_bready = 2'b11;
    #1;
    nv++;
    if (s_bvalid !== 2'b01 || s_b.resp !== 2'b00 || m_bready !== 1'b1 || m_wvalid !== 1'b0) begin
      nm++;
      $display("FAIL cc_bresp: bvalid=%b resp=%b bready=%b wvalid=%b want 01 00 1 0", s_bvalid, s_b.resp, m_bready, m_wvalid);
    end
    tick;
    nv++;
    if (s_bvalid !== 2'b00 || m_bready !== 1'b0) begin
      nm++;
      $display("FAIL cc_b_idle: bvalid=%b bready=%b want 00 0", s_bvalid, m_bready);
    end
    m_bvalid = 1'b0;
    tick;
  endtask

  task automatic test_w_held;
    s_w[0] = '0; s_w[0].data = 32'hC0; s_w[0].strb = 4'hF;
    s_wvalid = 2'b01; m_wready = 1'b1; m_awready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      if (c == 2) begin
        s_aw[0] = '0; s_aw[0].addr = 32'h8000_0100; s_aw[0].len = 4'd3;
        s_awvalid = 2'b01;
      end
      #1;
      nv++;
      if (s_wready !== 2'b00 || m_wvalid !== 1'b0) begin
        nm++;
        $display("FAIL wh_early%0d: wready=%b wvalid=%b want 00 0", c, s_wready, m_wvalid);
      end
      tick;
    end
    nv++;
    if (s_awready !== 2'b01 || s_wready !== 2'b00) begin
      nm++;
      $display("FAIL wh_aw: awready=%b wready=%b want 01 00", s_awready, s_wready);
    end
    tick;
    s_awvalid = 2'b00;
    for (int i = 0; i < 4; i++) begin
      s_w[0].data = 32'hC0 + i; s_w[0].last = (i == 3);
      #1;
      nv++;
      if (s_wready !== 2'b01 || m_w.data !== 32'hC0 + i || m_w.last !== (i == 3)) begin
        nm++;
        $display("FAIL wh_beat%0d: wready=%b data=%h last=%b want 01 %h", i, s_wready, m_w.data, m_w.last, 32'hC0 + i);
      end
      tick;
    end
    s_wvalid = 2'b00; m_bvalid = 1'b1; m_b.resp = 2'b00;
    #1;
    nv++;
    if (s_bvalid !== 2'b01) begin nm++; $display("FAIL wh_bresp: bvalid=%b want 01", s_bvalid); end
    tick;
    m_bvalid = 1'b0;
  endtask

  task automatic test_backpressure;
    int beat = 0, got = 0, lasts = 0, c = 0;
    s_ar[1] = '0; s_ar[1].addr = 32'hBFC0_0200; s_ar[1].len = 4'd3;
    s_arvalid = 2'b10; m_arready = 1'b1;
    tick;
    nv++;
    if (s_arready !== 2'b10) begin nm++; $display("FAIL bp_grant: arready=%b want 10", s_arready); end
    tick;
    s_arvalid = 2'b00;
    while (got < 4 && c < 30) begin
      m_rvalid = !(c >= 1 && c <= 5);
      s_rready = (c >= 7 && c <= 9) ? 2'b01 : 2'b11;
      m_r.data = 32'h300 + beat; m_r.last = (beat == 3);
      #1;
      nv++;
      if (m_rready !== s_rready[1] || s_rvalid !== {m_rvalid, 1'b0}) begin
        nm++;
        $display("FAIL bp_route%0d: rready=%b rvalid=%b want %b %b", c, m_rready, s_rvalid, s_rready[1], {m_rvalid, 1'b0});
      end
      if (s_rvalid[1] && s_rready[1]) begin
        nv++;
        if (s_r.data !== 32'h300 + got) begin
          nm++;
          $display("FAIL bp_order: got %h want %h", s_r.data, 32'h300 + got);
        end
        got++;
        if (s_r.last) lasts++;
      end
      if (m_rvalid && m_rready) beat++;
      tick;
      c++;
    end
    nv++;
    if (got != 4 || lasts != 1 || c != 12) begin
      nm++;
      $display("FAIL bp_count: beats=%0d lasts=%0d cycles=%0d want 4 1 12", got, lasts, c);
    end
    m_rvalid = 1'b1;
    #1;
    nv++;
    if (s_rvalid !== 2'b00) begin nm++; $display("FAIL bp_extra: rvalid=%b want 00", s_rvalid); end
    m_rvalid = 1'b0;
    tick;
  endtask

  task automatic test_fixed_prio;
    int n0 = 0;
    s_ar[0] = '0; s_ar[0].addr = 32'h8000_0400;
    s_ar[1] = '0; s_ar[1].addr = 32'hBFC0_0400;
    m_r.data = 32'h400; m_r.last = 1'b1;
    f_arvalid = 2'b11; f_m_arready = 1'b1; f_m_rvalid = 1'b1; f_rready = 2'b11;
    for (int i = 0; i < 12; i++) begin
      #1;
      nv++;
      if (f_arready[1] !== 1'b0 || f_rvalid[1] !== 1'b0) begin
        nm++;
        $display("FAIL fp_starve%0d: arready=%b rvalid=%b want icache lane 0", i, f_arready, f_rvalid);
      end
      if (f_arready[0]) n0++;
      if (i == 1) begin
        nv++;
        if (f_m_ar !== s_ar[0]) begin nm++; $display("FAIL fp_dcache_ar: got %h want %h", f_m_ar.addr, s_ar[0].addr); end
      end
      tick;
    end
    nv++;
    if (n0 != 4) begin nm++; $display("FAIL fp_dcache_grants: got %0d want 4", n0); end
    f_arvalid = 2'b10;
    #1;
    nv++;
    if (f_m_arvalid !== 1'b0) begin nm++; $display("FAIL fp_bubble: m_arvalid=%b want 0", f_m_arvalid); end
    tick;
    nv++;
    if (f_arready !== 2'b10 || f_m_ar !== s_ar[1]) begin
      nm++;
      $display("FAIL fp_icache_grant: arready=%b addr=%h want 10 bfc00400", f_arready, f_m_ar.addr);
    end
    tick;
    f_arvalid = 2'b00;
    #1;
    nv++;
    if (f_rvalid !== 2'b10 || f_r !== m_r || f_m_rready !== 1'b1) begin
      nm++;
      $display("FAIL fp_icache_r: rvalid=%b data=%h rready=%b want 10 %h 1", f_rvalid, f_r.data, f_m_rready, m_r.data);
    end
    tick;
    nv++;
    if ({f_awready, f_wready, f_bvalid, f_m_awvalid, f_m_wvalid, f_m_bready} !== 9'd0
        || f_b !== m_b || f_m_aw !== s_aw[0] || f_m_w !== s_w[0]) begin
      nm++;
      $display("FAIL fp_write_idle: hs=%b aw=%h w=%h", {f_awready, f_wready, f_bvalid, f_m_awvalid, f_m_wvalid, f_m_bready}, f_m_aw.addr, f_m_w.data);
    end
    f_m_rvalid = 1'b0;
  endtask

  initial begin
    s_ar = '0; s_aw = '0; s_w = '0; m_r = '0; m_b = '0;
    s_arvalid = '0; s_rready = '0; s_awvalid = '0; s_wvalid = '0; s_bready = '0;
    m_arready = 1'b0; m_rvalid = 1'b0; m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0;
    f_arvalid = '0; f_rready = '0; f_m_arready = 1'b0; f_m_rvalid = 1'b0;
    test_reset;
    test_round_robin;
    test_concurrent;
    test_w_held;
    test_backpressure;
    test_fixed_prio;
    $display("== %0d vectors applied, %0d miscompares ==", nv, nm);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
